cordic_job_arbiter: RTL and testbench
=====================================

Name: cordic_job_arbiter

Overview:
- Round-robin scheduler that shares one CORDIC engine (start/done handshake, 16-bit x/y results) among NREQ requesters.
- Each requester presents angle + mode under a req/gnt handshake. The arbiter sequences the engine one job at a time and returns results tagged with the requester ID over a valid/ready response port.
- Sits between client blocks and the CORDIC host engine.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ
- TIMEOUT_CYC, 32, engine watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester job request, level, held until granted
- req_angle  in  NREQ*16  packed angles; requester i at [16i+15:16i]
- req_mode  in  NREQ*2  packed CORDIC modes; requester i at [2i+1:2i]
- gnt  out  NREQ  one-hot, one-cycle grant pulse; operands latched that cycle
- eng_start  out  1  one-cycle start pulse to engine
- eng_angle  out  16  latched angle, stable from ISSUE until leaving WAIT
- eng_mode  out  2  latched mode, same stability as eng_angle
- eng_done  in  1  engine completion pulse
- eng_x  in  16  engine x result, valid with eng_done
- eng_y  in  16  engine y result, valid with eng_done
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  IDW  requester index of the response
- rsp_x  out  16  captured x result
- rsp_y  out  16  captured y result
- rsp_err  out  1  watchdog expiry flag; constant 0 without the optional feature
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, rr_ptr=0, wd counter=0.
  - All outputs 0: gnt, eng_start, eng_angle, eng_mode, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err, busy.
  - Reset mid-job abandons the job with no response. Any later eng_done is ignored because state is IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, select the first asserted req at or after rr_ptr, wrapping modulo NREQ.
  - In the same cycle: gnt[w]=1 for one cycle, latch req_angle/req_mode of w, latch id=w, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: eng_start=1 for exactly this cycle; clear wd counter; go to WAIT.
- WAIT:
  - On eng_done=1, capture eng_x/eng_y into rsp_x/rsp_y, set rsp_err=0, go to RESP.
  - eng_done seen in IDLE, ISSUE or RESP is ignored.
- RESP:
  - rsp_valid=1; rsp_id/rsp_x/rsp_y/rsp_err held stable until rsp_ready=1.
  - On handshake (rsp_valid & rsp_ready): rr_ptr = (id+1) mod NREQ, go to IDLE.
  - Earliest next grant is the cycle after the handshake.
- Latency: gnt to eng_start is 1 cycle. eng_done to rsp_valid is 1 cycle. Minimum turnaround is handshake + 1 cycle to next gnt.
- Fairness: after serving i, requester i has lowest priority. With all NREQ requesting continuously, grant order is 0,1,..,NREQ-1,0,...
- req dropped before grant: simply not considered. req stays high after grant: treated as a new job at the next arbitration.
- busy = (state != IDLE), registered with the state.
- Only one job is ever outstanding; no queueing.

Optional Feature:
- Macro: CORDIC_ARB_WATCHDOG_EN.
- Defined: wd counter increments every WAIT cycle. When it reaches TIMEOUT_CYC without eng_done, go to RESP with rsp_err=1 and rsp_x=rsp_y=0. rr_ptr advances normally.
- Not defined: no counter logic; WAIT waits indefinitely; rsp_err tied 0.

Test Plan:
- Single job: req=4'b0100, angle=16'h1000, mode=0; engine model returns x=16'h3A00, y=16'h2000 ten cycles after eng_start -> gnt=4'b0100 one cycle, eng_start next cycle with eng_angle=16'h1000, then rsp_valid with rsp_id=2, rsp_x=16'h3A00, rsp_y=16'h2000.
- Round-robin: req=4'b1111 held, rsp_ready=1 -> grant sequence 0,1,2,3,0; no requester granted twice before all others are served.
- Backpressure: rsp_ready=0 for 5 cycles in RESP, then 1 -> rsp_* stable all 5 cycles, no gnt issued; next gnt exactly 1 cycle after the handshake.
- Spurious done: eng_done pulsed in IDLE and in ISSUE -> no rsp_valid, state unaffected.
- Reset mid-WAIT: rst=0 for one edge during WAIT, then eng_done arrives -> all outputs 0, no response, rr_ptr=0.
- With CORDIC_ARB_WATCHDOG_EN, TIMEOUT_CYC=32, engine never asserts done -> rsp_valid 33 cycles after eng_start, with rsp_err=1 and rsp_x=rsp_y=0.

Source files
------------

// File: rtl/cordic_job_arbiter_if.sv
// cordic_job_arbiter_if
//   Bundles the three handshakes around the shared CORDIC engine:
//   - requester side : req, req_angle, req_mode (in) / gnt (out)
//   - engine side    : eng_start, eng_angle, eng_mode (out) / eng_done, eng_x, eng_y (in)
//   - response side  : rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err (out) / rsp_ready (in)
//   The master modport is the arbiter's view. The slave modport is the
//   surrounding clients and engine.
interface cordic_job_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*16-1:0] req_angle;
  logic [NREQ*2-1:0]  req_mode;
  logic [NREQ-1:0]    gnt;

  logic               eng_start;
  logic [15:0]        eng_angle;
  logic [1:0]         eng_mode;
  logic               eng_done;
  logic [15:0]        eng_x;
  logic [15:0]        eng_y;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_x;
  logic [15:0]        rsp_y;
  logic               rsp_err;

  modport master (
    input  req, req_angle, req_mode, eng_done, eng_x, eng_y, rsp_ready,
    output gnt, eng_start, eng_angle, eng_mode,
           rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err
  );

  modport slave (
    output req, req_angle, req_mode, eng_done, eng_x, eng_y, rsp_ready,
    input  gnt, eng_start, eng_angle, eng_mode,
           rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err
  );
endinterface

// File: rtl/cordic_job_arbiter.sv
// cordic_job_arbiter
//   Round-robin scheduler that shares one CORDIC engine among NREQ
//   requesters. Only one job is in flight at a time. The winner's
//   angle/mode are latched at grant, issued to the engine, and the result
//   is returned tagged with the requester ID over a valid/ready port.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-low reset
//   bus   : cordic_job_arbiter_if.master (requester, engine, response)
//   busy  : high whenever the FSM is not in IDLE
//
// Optional build macro:
//   CORDIC_ARB_WATCHDOG_EN - adds an engine watchdog. After TIMEOUT_CYC
//   WAIT cycles without eng_done, an error response is returned
//   (rsp_err=1, rsp_x=rsp_y=0). Without the macro, WAIT waits
//   indefinitely and rsp_err is tied low.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no job; arbitrate and grant in the same cycle
// ISSUE | eng_start pulse, watchdog cleared
// WAIT  | engine running; waiting for eng_done (or watchdog expiry)
// RESP  | rsp_valid held with stable payload until rsp_ready
module cordic_job_arbiter #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  cordic_job_arbiter_if.master  bus,
  output logic                  busy
);

  localparam int IW = IDW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [15:0]     angle_q, angle_d;
  logic [1:0]      mode_q, mode_d;
  logic [15:0]     x_q, x_d;
  logic [15:0]     y_q, y_d;
  logic            busy_q;
  logic [NREQ-1:0] gnt_d;

  logic            found;
  logic [IDW-1:0]  win;
  logic [IW-1:0]   idx;

`ifdef CORDIC_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0]  wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // Round-robin pick: first asserted request at or after rr_ptr, wrapping.
  // rr_ptr and k are both below NREQ, so one conditional subtract is enough
  // to wrap modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr_q} + IW'(k);
      if (idx >= IW'(NREQ)) begin
        idx = idx - IW'(NREQ);
      end
      if (!found && bus.req[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    angle_d  = angle_q;
    mode_d   = mode_q;
    x_d      = x_q;
    y_d      = y_q;
    gnt_d    = '0;
`ifdef CORDIC_ARB_WATCHDOG_EN
    wd_d     = wd_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d[win] = 1'b1;
          id_d       = win;
          angle_d    = bus.req_angle[int'(win)*16 +: 16];
          mode_d     = bus.req_mode[int'(win)*2 +: 2];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef CORDIC_ARB_WATCHDOG_EN
        wd_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
`ifdef CORDIC_ARB_WATCHDOG_EN
        wd_d = wd_q + 1'b1;
`endif
        if (bus.eng_done) begin
          x_d     = bus.eng_x;
          y_d     = bus.eng_y;
`ifdef CORDIC_ARB_WATCHDOG_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef CORDIC_ARB_WATCHDOG_EN
        else if (wd_d == WDW'(TIMEOUT_CYC)) begin
          x_d     = '0;
          y_d     = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
`endif
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          // Just-served requester drops to lowest priority.
          rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      angle_q  <= '0;
      mode_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
`ifdef CORDIC_ARB_WATCHDOG_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      angle_q  <= angle_d;
      mode_q   <= mode_d;
      x_q      <= x_d;
      y_q      <= y_d;
      busy_q   <= (state_d != S_IDLE);
`ifdef CORDIC_ARB_WATCHDOG_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  // Grant is decided combinationally in IDLE. It is masked during reset so
  // that no requester treats a reset cycle as a grant.
  assign bus.gnt       = rst ? gnt_d : '0;
  assign bus.eng_start = (state_q == S_ISSUE);
  assign bus.eng_angle = angle_q;
  assign bus.eng_mode  = mode_q;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_x     = x_q;
  assign bus.rsp_y     = y_q;
`ifdef CORDIC_ARB_WATCHDOG_EN
  assign bus.rsp_err   = err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign busy          = busy_q;

endmodule

// File: tb/tb_cordic_job_arbiter.sv
module tb_cordic_job_arbiter;

  logic clk;
  logic rst;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] ang_tab  [4] = '{16'h0111, 16'h0555, 16'h1000, 16'h7333};
  logic [1:0]  mode_tab [4] = '{2'd2, 2'd1, 2'd0, 2'd3};

  cordic_job_arbiter_if #(.NREQ(4), .IDW(2)) ifc ();

  cordic_job_arbiter #(
    .NREQ(4),
    .IDW(2),
    .TIMEOUT_CYC(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle with req already set. Expects requester `id`
  // to be granted now, runs the engine with done `lat` cycles after
  // eng_start, optionally pulses a spurious done in ISSUE, holds rsp_ready
  // low for `bp` RESP cycles, and returns in the IDLE cycle after the
  // handshake.
  task automatic serve(input int id, input int lat, input logic [15:0] x,
                       input logic [15:0] y, input int bp, input bit spur);
    logic [3:0] eg;
    eg = 4'b0001 << id;
    #1;
    chk("gnt", 32'(ifc.gnt), 32'(eg));
    chk("busy_at_gnt", 32'(busy), 0);
    step();
    chk("gnt_one_cycle", 32'(ifc.gnt), 0);
    chk("eng_start", 32'(ifc.eng_start), 1);
    chk("eng_angle", 32'(ifc.eng_angle), 32'(ang_tab[id]));
    chk("eng_mode", 32'(ifc.eng_mode), 32'(mode_tab[id]));
    chk("busy_issue", 32'(busy), 1);
    if (spur) begin
      ifc.eng_done = 1'b1;
      ifc.eng_x    = 16'hDEAD;
      ifc.eng_y    = 16'hBEEF;
    end
    for (int i = 0; i < lat; i++) begin
      step();
      ifc.eng_done = 1'b0;
      chk("no_early_rsp", 32'(ifc.rsp_valid), 0);
      chk("start_pulse_once", 32'(ifc.eng_start), 0);
    end
    chk("angle_held", 32'(ifc.eng_angle), 32'(ang_tab[id]));
    ifc.eng_done = 1'b1;
    ifc.eng_x    = x;
    ifc.eng_y    = y;
    step();
    ifc.eng_done = 1'b0;
    ifc.eng_x    = 16'h0;
    ifc.eng_y    = 16'h0;
    chk("rsp_valid", 32'(ifc.rsp_valid), 1);
    chk("rsp_id", 32'(ifc.rsp_id), id);
    chk("rsp_x", 32'(ifc.rsp_x), 32'(x));
    chk("rsp_y", 32'(ifc.rsp_y), 32'(y));
    chk("rsp_err", 32'(ifc.rsp_err), 0);
    if (bp > 0) begin
      ifc.rsp_ready = 1'b0;
      for (int i = 0; i < bp; i++) begin
        step();
        chk("bp_valid", 32'(ifc.rsp_valid), 1);
        chk("bp_id", 32'(ifc.rsp_id), id);
        chk("bp_x", 32'(ifc.rsp_x), 32'(x));
        chk("bp_y", 32'(ifc.rsp_y), 32'(y));
        chk("bp_no_gnt", 32'(ifc.gnt), 0);
      end
    end
    ifc.rsp_ready = 1'b1;
    step();
    chk("rsp_drop", 32'(ifc.rsp_valid), 0);
    chk("busy_drop", 32'(busy), 0);
  endtask

  initial begin
    rst           = 1'b0;
    ifc.req       = 4'b1111;
    ifc.req_angle = {16'h7333, 16'h1000, 16'h0555, 16'h0111};
    ifc.req_mode  = 8'b11_00_01_10;
    ifc.eng_done  = 1'b0;
    ifc.eng_x     = 16'h0;
    ifc.eng_y     = 16'h0;
    ifc.rsp_ready = 1'b0;

    // Reset state (requests asserted, grant must stay masked)
    repeat (2) step();
    chk("rst_gnt", 32'(ifc.gnt), 0);
    chk("rst_eng_start", 32'(ifc.eng_start), 0);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 0);
    chk("rst_rsp_id", 32'(ifc.rsp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    ifc.req = 4'b0000;
    rst     = 1'b1;
    step();
    chk("idle_no_req_gnt", 32'(ifc.gnt), 0);

    // Round robin with all requesting: 0,1,2,3,0
    ifc.req       = 4'b1111;
    ifc.rsp_ready = 1'b1;
    serve(0, 3, 16'h0A01, 16'h0B01, 0, 1'b0);
    serve(1, 2, 16'h0A02, 16'h0B02, 0, 1'b0);
    serve(2, 4, 16'h0A03, 16'h0B03, 0, 1'b0);
    serve(3, 1, 16'h0A04, 16'h0B04, 0, 1'b0);
    serve(0, 2, 16'h0A05, 16'h0B05, 0, 1'b0);

    // Single job from requester 2 (pointer now at 1)
    ifc.req = 4'b0100;
    serve(2, 10, 16'h3A00, 16'h2000, 0, 1'b0);

    // Backpressure: pointer at 3, req 0 and 1 -> 0 wins, then 1 right after
    ifc.req = 4'b0011;
    serve(0, 4, 16'h1234, 16'h5678, 5, 1'b0);
    serve(1, 2, 16'h1111, 16'h2222, 0, 1'b0);

    // Spurious done in IDLE
    ifc.req      = 4'b0000;
    ifc.eng_done = 1'b1;
    ifc.eng_x    = 16'hDEAD;
    step();
    ifc.eng_done = 1'b0;
    chk("spur_idle_valid", 32'(ifc.rsp_valid), 0);
    chk("spur_idle_busy", 32'(busy), 0);
    step();
    chk("spur_idle_valid2", 32'(ifc.rsp_valid), 0);

    // Spurious done in ISSUE (pointer at 2, only 3 requests)
    ifc.req = 4'b1000;
    serve(3, 5, 16'h4444, 16'h5555, 0, 1'b1);

    // Pointer back at 0; requester 1 wins, pointer then at 2
    ifc.req = 4'b0010;
    serve(1, 3, 16'h6666, 16'h7777, 0, 1'b0);

    // Reset in the middle of WAIT
    ifc.req = 4'b0100;
    #1;
    chk("mid_gnt", 32'(ifc.gnt), 32'(4'b0100));
    step();
    ifc.req = 4'b0000;
    chk("mid_start", 32'(ifc.eng_start), 1);
    step();
    step();
    chk("mid_busy_wait", 32'(busy), 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mrst_gnt", 32'(ifc.gnt), 0);
    chk("mrst_eng_start", 32'(ifc.eng_start), 0);
    chk("mrst_eng_angle", 32'(ifc.eng_angle), 0);
    chk("mrst_eng_mode", 32'(ifc.eng_mode), 0);
    chk("mrst_rsp_valid", 32'(ifc.rsp_valid), 0);
    chk("mrst_rsp_id", 32'(ifc.rsp_id), 0);
    chk("mrst_rsp_x", 32'(ifc.rsp_x), 0);
    chk("mrst_rsp_y", 32'(ifc.rsp_y), 0);
    chk("mrst_rsp_err", 32'(ifc.rsp_err), 0);
    chk("mrst_busy", 32'(busy), 0);
    ifc.eng_done = 1'b1;
    ifc.eng_x    = 16'h1234;
    ifc.eng_y    = 16'h4321;
    step();
    ifc.eng_done = 1'b0;
    chk("late_done_valid", 32'(ifc.rsp_valid), 0);
    chk("late_done_busy", 32'(busy), 0);
    chk("late_done_x", 32'(ifc.rsp_x), 0);
    step();
    chk("late_done_valid2", 32'(ifc.rsp_valid), 0);

    // Pointer must be 0 after reset: all requesting -> 0 wins
    ifc.req = 4'b1111;
    serve(0, 2, 16'h0F0F, 16'hF0F0, 0, 1'b0);

`ifdef CORDIC_ARB_WATCHDOG_EN
    begin
      int cnt;
      ifc.req = 4'b0010;
      #1;
      chk("wd_gnt", 32'(ifc.gnt), 32'(4'b0010));
      step();
      ifc.req = 4'b0000;
      chk("wd_start", 32'(ifc.eng_start), 1);
      cnt = 0;
      while (!ifc.rsp_valid && cnt < 100) begin
        step();
        cnt++;
      end
      chk("wd_latency", cnt, 33);
      chk("wd_err", 32'(ifc.rsp_err), 1);
      chk("wd_x", 32'(ifc.rsp_x), 0);
      chk("wd_y", 32'(ifc.rsp_y), 0);
      chk("wd_id", 32'(ifc.rsp_id), 1);
      ifc.rsp_ready = 1'b1;
      step();
      chk("wd_drop", 32'(ifc.rsp_valid), 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
